fpu_issue_scoreboard: RTL and testbench
=======================================

Name: fpu_issue_scoreboard

Overview:
- Sits directly upstream of the FPU core; gates each decoded float instruction before it enters the FPU.
- Stalls on read-after-write hazards against the FPU's fixed-latency writeback pipeline. The float register file has no bypass, so a result is visible to readers only after its writeback edge.
- Keeps a per-register countdown of pending writes and a stall-cycle performance counter.

Parameters:
- NREG, 32, number of float registers tracked (register index width 5)
- WB_LATENCY, 5, cycles from issue edge to register-file write edge (matches the FPU writeback shift depth)
- CNT_W, 3, width of each per-register countdown; must hold WB_LATENCY

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded float instruction present this cycle
- in_rs1  in  5  source 1 index (inst[19:15])
- in_rs2  in  5  source 2 index (inst[24:20]); also the store-data source
- in_rd  in  5  destination index (inst[11:7])
- in_use_rs1  in  1  instruction reads float rs1
- in_use_rs2  in  1  instruction reads float rs2
- in_write_rd  in  1  instruction writes float rd (add/sub, mult, load, int-to-float cvt)
- ext_stall  in  1  integer-side hold; blocks issue, does not freeze counters
- issue  out  1  instruction accepted into the FPU this cycle
- hazard_stall  out  1  instruction held because of a float RAW hazard
- busy_mask  out  32  bit i set while register i has a pending write
- stall_count  out  32  number of cycles hazard_stall was high

Behaviour:
- Reset (rst_n low, asynchronous):
  - all countdowns are 0; busy_mask = 0; stall_count = 0.
  - issue and hazard_stall are combinational; with in_valid low both are 0.
- Hazard, combinational on current state:
  - hazard = (in_use_rs1 & cnt[in_rs1]!=0) | (in_use_rs2 & cnt[in_rs2]!=0).
  - hazard_stall = in_valid & hazard.
  - issue = in_valid & ~hazard & ~ext_stall.
- Countdown update, each rising edge, per register i:
  - if issue & in_write_rd & in_rd==i: cnt[i] <= WB_LATENCY.
  - else if cnt[i]!=0: cnt[i] <= cnt[i]-1.
  - else cnt[i] holds 0.
- Timing: a writer issued in cycle T blocks readers of rd in cycles T+1..T+WB_LATENCY. A dependent reader issues at earliest in T+WB_LATENCY+1, the first cycle after the register-file write edge.
- Same-instruction read and write of the same register (rs==rd): the read uses the old value and is not a hazard; rd is marked busy after the edge.
- WAW: a new writer to a busy rd reloads cnt to WB_LATENCY. With a single fixed latency, the later write lands last.
- ext_stall high:
  - issue = 0 and no new counter is loaded.
  - existing counters keep decrementing, because the FPU pipeline free-runs.
  - hazard_stall still reflects the hazard.
- stall_count increments by 1 on each edge where hazard_stall=1. It wraps from 0xFFFFFFFF to 0.
- busy_mask[i] = (cnt[i]!=0), derived from registers and glitch-free.
- Sources that are not float registers (integer operand of int-to-float cvt, memory address) are not tracked here. Float-to-int results go to the integer pipeline and are never marked busy.
- Reset asserted mid-operation clears all pending state immediately. Writebacks still in flight in the FPU are not cancelled. The system resets the FPU on the same rst_n.
- No input is registered; the downstream FPU samples its inst on the same edge at which issue is high.

Test Plan:
- Reset, then in_valid=1, rs1=3, rs2=4, use both, write_rd, rd=5 -> issue=1; after the edge busy_mask=0x00000020 and cnt[5]=5.
- Writer rd=5 issued at T; reader use_rs1, rs1=5 held at in_valid from T+1 -> hazard_stall=1 and issue=0 in T+1..T+5; issue=1 in T+6; stall_count=5.
- Writer rd=7 at T, second writer rd=7 at T+2 (no source use) -> busy_mask bit 7 stays set through T+7 and clears in T+8.
- Reader rs1=9, rs2=9, rd=9 with cnt[9]=0 -> issue=1, no stall; cnt[9]=5 next cycle.
- Writer rd=2 at T, ext_stall=1 during T+1..T+8 with reader rs2=2 valid:
  - hazard_stall=1 in T+1..T+5, then 0 from T+6.
  - issue=0 throughout and stall_count=5.
  - issue=1 in T+9 once ext_stall drops.
- Three overlapping writers (rd=1, 2, 3) then rst_n pulsed low mid-window -> busy_mask=0 and stall_count=0 immediately; a reader of rd=1 issues the cycle after reset releases.

Source files
------------

// File: rtl/fpu_issue_scoreboard.sv
// rtl/fpu_issue_scoreboard.sv - RAW-hazard issue gate for the FPU with per-register writeback countdowns
// A register stays busy from its writer's issue edge until its register-file write edge.
module fpu_issue_scoreboard #(
  parameter int NREG       = 32,
  parameter int WB_LATENCY = 5,
  parameter int CNT_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic            in_write_rd,
  input  logic            ext_stall,
  output logic            issue,
  output logic            hazard_stall,
  output logic [NREG-1:0] busy_mask,
  output logic [31:0]     stall_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WB_LATENCY);

  logic [CNT_W-1:0] cnt [NREG];
  logic             hazard;
  logic             load;

  always_comb begin
    hazard       = (in_use_rs1 && cnt[in_rs1] != '0) ||
                   (in_use_rs2 && cnt[in_rs2] != '0);
    hazard_stall = in_valid && hazard;
    issue        = in_valid && !hazard && !ext_stall;
    load         = issue && in_write_rd;
  end

  // Counters free-run under ext_stall because the FPU pipeline never stops.
  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (load && in_rd == 5'(i)) begin
        cnt_q <= LOAD_VAL;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end

    assign cnt[i]       = cnt_q;
    assign busy_mask[i] = |cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard_stall) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// tb/tb_fpu_issue_scoreboard.sv - directed self-checking bench for fpu_issue_scoreboard
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_fpu_issue_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic        in_write_rd;
  logic        ext_stall;
  logic        issue;
  logic        hazard_stall;
  logic [31:0] busy_mask;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_issue_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_use_rs1   (in_use_rs1),
    .in_use_rs2   (in_use_rs2),
    .in_write_rd  (in_write_rd),
    .ext_stall    (ext_stall),
    .issue        (issue),
    .hazard_stall (hazard_stall),
    .busy_mask    (busy_mask),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic w, input logic xs);
    in_valid    = v;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_use_rs1  = u1;
    in_use_rs2  = u2;
    in_write_rd = w;
    ext_stall   = xs;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    check("reset_issue", {31'd0, issue}, 32'd0);
    check("reset_hazard", {31'd0, hazard_stall}, 32'd0);
    check("reset_busy", busy_mask, 32'd0);
    check("reset_stall_count", stall_count, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // First writer: rd=5 goes busy after the edge
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t1_issue", {31'd0, issue}, 32'd1);
    tick();
    idle();
    check("t1_busy", busy_mask, 32'h0000_0020);
    check("t1_no_valid_no_stall", {31'd0, hazard_stall}, 32'd0);

    // RAW: reader of rd=5 held T+1..T+5, issues T+6
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_writer_issue", {31'd0, issue}, 32'd1);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("t2_stall_T%0d", c), {31'd0, hazard_stall}, 32'd1);
      check($sformatf("t2_noissue_T%0d", c), {31'd0, issue}, 32'd0);
      tick();
      #1;
    end
    check("t2_issue_T6", {31'd0, issue}, 32'd1);
    check("t2_stall_T6", {31'd0, hazard_stall}, 32'd0);
    check("t2_stall_count", stall_count, 32'd5);
    tick();
    idle();

    // WAW reload: rd=7 at T and T+2, busy through T+7, clear at T+8
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_second_writer_issue", {31'd0, issue}, 32'd1);
    tick();
    idle();
    for (int c = 3; c <= 7; c++) begin
      check($sformatf("t3_busy7_T%0d", c), busy_mask, 32'h0000_0080);
      tick();
    end
    check("t3_clear_T8", busy_mask, 32'd0);

    // Same-instruction rs==rd is not a hazard
    do_reset();
    drive(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_issue", {31'd0, issue}, 32'd1);
    check("t4_no_stall", {31'd0, hazard_stall}, 32'd0);
    tick();
    idle();
    check("t4_busy9", busy_mask, 32'h0000_0200);

    // ext_stall: counters keep running, hazard_stall tracks the hazard only
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("t5_stall_T%0d", c), {31'd0, hazard_stall}, (c <= 5) ? 32'd1 : 32'd0);
      check($sformatf("t5_noissue_T%0d", c), {31'd0, issue}, 32'd0);
      tick();
    end
    drive(1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_issue_T9", {31'd0, issue}, 32'd1);
    check("t5_stall_count", stall_count, 32'd5);
    tick();
    idle();

    // Mid-window asynchronous reset clears all pending state
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("t6_busy_before", busy_mask, 32'h0000_000E);
    check("t6_count_before", stall_count, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_reset", busy_mask, 32'd0);
    check("t6_count_reset", stall_count, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_reader_issue", {31'd0, issue}, 32'd1);
    check("t6_reader_no_stall", {31'd0, hazard_stall}, 32'd0);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
